uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_tx_param.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter fed by a small transmit FIFO, with optional parity and 1 or 2 stop bits.
// The serial line is registered from the current FSM state, so the line trails the state by one clock.
module uart_tx_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset_b,
    input  logic [DATA_W-1:0]             TX_Data_in,
    input  logic                          TX_Write_en,
    input  logic                          Overflow_clr,
    output logic                          TX_Data_out,
    output logic                          TX_Ready_To_Send,
    output logic                          TX_Busy,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_Level,
    output logic                          TX_Overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [3:0]    DATA_LAST  = 4'(DATA_W - 1);
    localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic          ODD_PARITY = (PARITY == 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_W-1:0] fifoMem_q [FIFO_DEPTH];
    logic [AW-1:0]     wrPtr_q, rdPtr_q;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [2:0]        state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [3:0]        bitCnt_q, bitCnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parityBit_q, parityBit_d;
    logic              txLine_q, txLine_d;

    logic              full, empty, push, pop, bitDone;
    logic [DATA_W-1:0] headWord;

    assign full     = (level_q == LEVEL_FULL);
    assign empty    = (level_q == '0);
    assign push     = TX_Write_en && !full;
    assign bitDone  = (baud_q == BAUD_LAST);
    assign headWord = fifoMem_q[rdPtr_q];

    // Storage has no reset: a zero level already marks every entry as stale.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= TX_Data_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parityBit_d = parityBit_q;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bitDone) begin
                    bitCnt_d = '0;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (bitDone) begin
                    shift_d = shift_q >> 1;
                    if (bitCnt_q == DATA_LAST) begin
                        bitCnt_d = '0;
                        state_d  = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bitDone) begin
                    bitCnt_d = '0;
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (bitDone) begin
                    if (bitCnt_q == STOP_LAST) begin
                        bitCnt_d = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The baud counter reloads at every bit boundary so frames never drift.
        if (state_q == S_IDLE) begin
            baud_d = '0;
        end else begin
            baud_d = bitDone ? '0 : baud_q + BW'(1);
        end

        if (pop) begin
            shift_d     = headWord;
            parityBit_d = (^headWord) ^ ODD_PARITY;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A dropped write wins over a simultaneous clear.
        if (TX_Write_en && full) begin
            ovf_d = 1'b1;
        end else if (Overflow_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        case (state_q)
            S_START:  txLine_d = 1'b0;
            S_DATA:   txLine_d = shift_q[0];
            S_PARITY: txLine_d = parityBit_q;
            default:  txLine_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parityBit_q <= 1'b0;
            txLine_q    <= 1'b1;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            baud_q      <= baud_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parityBit_q <= parityBit_d;
            txLine_q    <= txLine_d;
        end
    end

    assign TX_Data_out      = txLine_q;
    assign TX_Busy          = (state_q != S_IDLE);
    assign TX_Ready_To_Send = !full;
    assign FIFO_Level       = level_q;
    assign TX_Overflow      = ovf_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: four instances cover plain 8N1, even/odd parity and 7-bit with two stops.
// Expected frames are queued at write time; a monitor captures each frame cycle by cycle and compares.
module tb_uart_tx_param;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_b;
    logic [7:0] dataIn;
    logic [3:0] wrEn;
    logic       ovfClr;
    logic [3:0] txLine, rts, busy, ovf;
    logic [4:0] level [4];

    int    checks        = 0;
    int    errors        = 0;
    int    cycleCount    = 0;
    int    pendingFrames = 0;
    int    activeIdx     = 0;
    bit    monitorEn     = 1'b0;
    string frameQ[$];
    int    startQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dutPlain (
        .clk(clk), .reset_b(reset_b), .TX_Data_in(dataIn), .TX_Write_en(wrEn[0]), .Overflow_clr(ovfClr),
        .TX_Data_out(txLine[0]), .TX_Ready_To_Send(rts[0]), .TX_Busy(busy[0]), .FIFO_Level(level[0]),
        .TX_Overflow(ovf[0]));

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dutEven (
        .clk(clk), .reset_b(reset_b), .TX_Data_in(dataIn), .TX_Write_en(wrEn[1]), .Overflow_clr(ovfClr),
        .TX_Data_out(txLine[1]), .TX_Ready_To_Send(rts[1]), .TX_Busy(busy[1]), .FIFO_Level(level[1]),
        .TX_Overflow(ovf[1]));

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dutOdd (
        .clk(clk), .reset_b(reset_b), .TX_Data_in(dataIn), .TX_Write_en(wrEn[2]), .Overflow_clr(ovfClr),
        .TX_Data_out(txLine[2]), .TX_Ready_To_Send(rts[2]), .TX_Busy(busy[2]), .FIFO_Level(level[2]),
        .TX_Overflow(ovf[2]));

    uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dutSeven (
        .clk(clk), .reset_b(reset_b), .TX_Data_in(dataIn[6:0]), .TX_Write_en(wrEn[3]), .Overflow_clr(ovfClr),
        .TX_Data_out(txLine[3]), .TX_Ready_To_Send(rts[3]), .TX_Busy(busy[3]), .FIFO_Level(level[3]),
        .TX_Overflow(ovf[3]));

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference 8N1 frame, written in line order (start bit first).
    function automatic string makeFrame(input logic [7:0] d);
        string s;
        s = "0";
        for (int b = 0; b < 8; b++) begin
            s = {s, d[b] ? "1" : "0"};
        end
        s = {s, "1"};
        return s;
    endfunction

    task automatic applyStimulus(input int idx, input logic [7:0] data, input string frame, input bit checkLatency);
        @(negedge clk);
        dataIn    = data;
        wrEn[idx] = 1'b1;
        frameQ.push_back(frame);
        startQ.push_back(checkLatency ? cycleCount + 3 : -1);
        pendingFrames++;
        @(negedge clk);
        wrEn[idx] = 1'b0;
    endtask

    task automatic waitFrames(input int budget, input string name);
        int n = 0;
        while (pendingFrames > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, pendingFrames, 0);
    endtask

    // Start rule per frame: exact cycle (>=0), don't care (-1), or abutting the previous frame (-2).
    initial begin : monitor
        string       expFrame;
        int          rule;
        int          nCyc;
        int          startCyc;
        int          lastEnd;
        logic [63:0] actW;
        logic [63:0] expW;
        lastEnd = -100;
        forever begin
            @(negedge clk);
            if (monitorEn && reset_b && txLine[activeIdx] == 1'b0) begin
                startCyc = cycleCount;
                if (frameQ.size() == 0) begin
                    checkOutput("unexpected_frame", 1, 0);
                end else begin
                    expFrame = frameQ.pop_front();
                    rule     = startQ.pop_front();
                    nCyc     = expFrame.len() * CPB;
                    actW     = '0;
                    expW     = '0;
                    for (int c = 0; c < nCyc; c++) begin
                        if (c > 0) @(negedge clk);
                        actW[c] = txLine[activeIdx];
                        expW[c] = (expFrame.getc(c / CPB) == "1");
                    end
                    checkOutput($sformatf("frame_%s", expFrame), actW, expW);
                    if (rule >= 0) begin
                        checkOutput("frame_start_cycle", startCyc, rule);
                    end else if (rule == -2) begin
                        checkOutput("back_to_back_start", startCyc, lastEnd);
                    end
                    lastEnd = startCyc + nCyc;
                    pendingFrames--;
                end
            end
        end
    end

    initial begin : stimulus
        int peak;
        bit lowSeen;
        reset_b = 1'b0;
        wrEn    = '0;
        dataIn  = '0;
        ovfClr  = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("reset_line_%0d", i), txLine[i], 1);
            checkOutput($sformatf("reset_busy_%0d", i), busy[i], 0);
            checkOutput($sformatf("reset_level_%0d", i), level[i], 0);
            checkOutput($sformatf("reset_ready_%0d", i), rts[i], 1);
            checkOutput($sformatf("reset_ovf_%0d", i), ovf[i], 0);
        end
        @(negedge clk);
        reset_b = 1'b1;
        repeat (3) @(negedge clk);
        monitorEn = 1'b1;

        // Plain 8N1 frame with the two-edge start latency.
        activeIdx = 0;
        applyStimulus(0, 8'h44, "0001000101", 1'b1);
        @(negedge clk);
        checkOutput("s1_busy_during", busy[0], 1);
        waitFrames(200, "s1_frame_done");
        checkOutput("s1_busy_after", busy[0], 0);
        checkOutput("s1_line_idle", txLine[0], 1);

        activeIdx = 1;
        applyStimulus(1, 8'h31, "01000110011", 1'b0);
        waitFrames(200, "s2_even_done");
        activeIdx = 2;
        applyStimulus(2, 8'h31, "01000110001", 1'b0);
        waitFrames(200, "s2_odd_done");

        activeIdx = 3;
        applyStimulus(3, 8'h29, "0100101011", 1'b0);
        waitFrames(200, "s3_frame_done");

        // Twenty-cycle write burst: 17 accepted, the last 3 dropped.
        activeIdx = 0;
        peak      = 0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            dataIn  = 8'(i * 29 + 7);
            wrEn[0] = 1'b1;
            if (i < 17) begin
                frameQ.push_back(makeFrame(dataIn));
                startQ.push_back(i == 0 ? -1 : -2);
                pendingFrames++;
            end
            @(negedge clk);
            if (int'(level[0]) > peak) peak = int'(level[0]);
        end
        wrEn[0] = 1'b0;
        checkOutput("s4_level_full", level[0], 16);
        checkOutput("s4_ready_low", rts[0], 0);
        checkOutput("s4_overflow", ovf[0], 1);
        checkOutput("s4_level_peak", peak, 16);

        ovfClr = 1'b1;
        @(negedge clk);
        ovfClr = 1'b0;
        checkOutput("s5_clear", ovf[0], 0);
        ovfClr  = 1'b1;
        wrEn[0] = 1'b1;
        dataIn  = 8'hEE;
        @(negedge clk);
        ovfClr  = 1'b0;
        wrEn[0] = 1'b0;
        checkOutput("s5_overflow_beats_clear", ovf[0], 1);
        checkOutput("s5_dropped_write_level", level[0], 16);
        waitFrames(17 * 40 + 100, "s4_all_frames_done");
        checkOutput("s4_busy_after", busy[0], 0);
        checkOutput("s5_sticky", ovf[0], 1);
        ovfClr = 1'b1;
        @(negedge clk);
        ovfClr = 1'b0;
        checkOutput("s5_final_clear", ovf[0], 0);

        // Asynchronous reset in the middle of a data phase with three words queued.
        monitorEn = 1'b0;
        @(negedge clk);
        dataIn  = 8'h00;
        wrEn[0] = 1'b1;
        repeat (4) @(negedge clk);
        wrEn[0] = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("s6_pre_level", level[0], 3);
        checkOutput("s6_pre_line_low", txLine[0], 0);
        #1 reset_b = 1'b0;
        #1;
        checkOutput("s6_async_line", txLine[0], 1);
        checkOutput("s6_async_level", level[0], 0);
        checkOutput("s6_async_busy", busy[0], 0);
        checkOutput("s6_async_ready", rts[0], 1);
        @(negedge clk);
        reset_b = 1'b1;
        lowSeen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (!txLine[0]) lowSeen = 1'b1;
        end
        checkOutput("s6_line_stays_idle", lowSeen, 0);
        checkOutput("s6_level_after", level[0], 0);
        checkOutput("s6_busy_after", busy[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
